// File: rtl/legv8_ctrl_pkg.sv
// Shared encodings, FSM states and the control-word bundle for the LEGv8
// multicycle control sequencer.
package legv8_ctrl_pkg;

    localparam logic [10:0] OP_ADD  = 11'h458;
    localparam logic [10:0] OP_SUB  = 11'h658;
    localparam logic [10:0] OP_AND  = 11'h450;
    localparam logic [10:0] OP_ORR  = 11'h550;
    localparam logic [10:0] OP_LDUR = 11'h7C2;
    localparam logic [10:0] OP_STUR = 11'h7C0;
    localparam logic [9:0]  OP_ADDI = 10'h244;
    localparam logic [9:0]  OP_SUBI = 10'h344;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_ORR = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01001;

    // Register 31 reads as zero, so writes to it are suppressed.
    localparam logic [4:0] XZR = 5'd31;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEM    = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE  = 2'd0,
        CLS_ALU   = 2'd1,
        CLS_LOAD  = 2'd2,
        CLS_STORE = 2'd3
    } instr_class_t;

    typedef struct packed {
        logic [4:0]  sa;
        logic [4:0]  sb;
        logic [4:0]  da;
        logic        w;
        logic [4:0]  fs;
        logic        cin;
        logic        selbork;
        logic [63:0] k;
        logic        tri_b_to_d;
        logic        tri_f_to_d;
        logic        tri_f_to_a;
        logic        tri_out_to_d;
        logic        write_en;
        logic        read_en;
    } ctrl_word_t;

    localparam ctrl_word_t CW_ZERO = '0;

    function automatic logic [63:0] zext_imm12(input logic [11:0] imm);
        return {52'd0, imm};
    endfunction

    function automatic logic [63:0] sext_dt(input logic [8:0] dt);
        return {{55{dt[8]}}, dt};
    endfunction

endpackage

// File: rtl/legv8_decoder.sv
// Combinational decode of a latched LEGv8 instruction into its class and the
// union of every control field it uses across EXEC and MEM.
module legv8_decoder
    import legv8_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output instr_class_t iclass,
    output ctrl_word_t   cw,
    output logic         illegal
);

    logic [10:0] op11_s;
    logic [9:0]  op10_s;
    logic [4:0]  rd_s;
    logic [4:0]  rn_s;
    logic [4:0]  rm_s;
    logic [11:0] imm12_s;
    logic [8:0]  dt_s;

    assign op11_s  = instr[31:21];
    assign op10_s  = instr[31:22];
    assign rd_s    = instr[4:0];
    assign rn_s    = instr[9:5];
    assign rm_s    = instr[20:16];
    assign imm12_s = instr[21:10];
    assign dt_s    = instr[20:12];

    // Opcode match; I-type opcodes are only considered when no 11-bit opcode hits.
    always_comb begin
        cw      = CW_ZERO;
        iclass  = CLS_NONE;
        illegal = 1'b0;
        case (op11_s)
            OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                iclass        = CLS_ALU;
                cw.sa         = rn_s;
                cw.sb         = rm_s;
                cw.da         = rd_s;
                cw.w          = (rd_s != XZR);
                cw.tri_f_to_d = 1'b1;
                case (op11_s)
                    OP_AND:  cw.fs = FS_AND;
                    OP_ORR:  cw.fs = FS_ORR;
                    OP_SUB: begin
                        cw.fs  = FS_SUB;
                        cw.cin = 1'b1;
                    end
                    default: cw.fs = FS_ADD;
                endcase
            end
            OP_LDUR: begin
                iclass          = CLS_LOAD;
                cw.sa           = rn_s;
                cw.da           = rd_s;
                cw.w            = (rd_s != XZR);
                cw.fs           = FS_ADD;
                cw.selbork      = 1'b1;
                cw.k            = sext_dt(dt_s);
                cw.tri_f_to_a   = 1'b1;
                cw.tri_out_to_d = 1'b1;
                cw.read_en      = 1'b1;
            end
            OP_STUR: begin
                iclass        = CLS_STORE;
                cw.sa         = rn_s;
                cw.sb         = rd_s;
                cw.fs         = FS_ADD;
                cw.selbork    = 1'b1;
                cw.k          = sext_dt(dt_s);
                cw.tri_f_to_a = 1'b1;
                cw.tri_b_to_d = 1'b1;
                cw.write_en   = 1'b1;
            end
            default: begin
                case (op10_s)
                    OP_ADDI, OP_SUBI: begin
                        iclass        = CLS_ALU;
                        cw.sa         = rn_s;
                        cw.da         = rd_s;
                        cw.w          = (rd_s != XZR);
                        cw.selbork    = 1'b1;
                        cw.k          = zext_imm12(imm12_s);
                        cw.tri_f_to_d = 1'b1;
                        if (op10_s == OP_SUBI) begin
                            cw.fs  = FS_SUB;
                            cw.cin = 1'b1;
                        end else begin
                            cw.fs  = FS_ADD;
                            cw.cin = 1'b0;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/legv8_control_unit.sv
// Multicycle LEGv8 control sequencer: accepts one instruction per handshake and
// walks it through DECODE/EXEC/MEM/DONE with fully registered control outputs.
module legv8_control_unit
    import legv8_ctrl_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        done,
    output logic        illegal,
    output logic [4:0]  SA,
    output logic [4:0]  SB,
    output logic [4:0]  DA,
    output logic        W,
    output logic [4:0]  FS,
    output logic        Cin,
    output logic        selbork,
    output logic [63:0] k,
    output logic        triSelBtoD,
    output logic        triSelFtoD,
    output logic        triSelFtoA,
    output logic        triSelOuttoD,
    output logic        writeEn,
    output logic        readEn
);

    state_t       state_r;
    state_t       state_next_s;
    logic [31:0]  instr_r;
    ctrl_word_t   cw_r;
    ctrl_word_t   cw_next_s;
    logic         ready_r;
    logic         done_r;
    logic         illegal_r;
    logic         illegal_next_s;
    logic         accept_s;
    instr_class_t dec_class_s;
    ctrl_word_t   dec_cw_s;
    logic         dec_illegal_s;

    legv8_decoder u_decoder (
        .instr   (instr_r),
        .iclass  (dec_class_s),
        .cw      (dec_cw_s),
        .illegal (dec_illegal_s)
    );

    // ready_r is only ever high in IDLE, so it alone qualifies the handshake.
    assign accept_s = instr_valid & ready_r;

    // State register and instruction latch.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= IDLE;
            instr_r <= 32'd0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                instr_r <= instr;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_next_s   = state_r;
        illegal_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_next_s = DECODE;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DECODE: begin
                if (dec_illegal_s) begin
                    state_next_s   = IDLE;
                    illegal_next_s = 1'b1;
                end else begin
                    state_next_s = EXEC;
                end
            end
            EXEC: begin
                if ((dec_class_s == CLS_LOAD) || (dec_class_s == CLS_STORE)) begin
                    state_next_s = MEM;
                end else begin
                    state_next_s = DONE;
                end
            end
            MEM:     state_next_s = DONE;
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // Control word for the state being entered; memory ops only drive the address path in EXEC.
    always_comb begin
        cw_next_s = CW_ZERO;
        case (state_next_s)
            EXEC: begin
                cw_next_s = dec_cw_s;
                if ((dec_class_s == CLS_LOAD) || (dec_class_s == CLS_STORE)) begin
                    cw_next_s.sb           = 5'd0;
                    cw_next_s.da           = 5'd0;
                    cw_next_s.w            = 1'b0;
                    cw_next_s.tri_b_to_d   = 1'b0;
                    cw_next_s.tri_out_to_d = 1'b0;
                    cw_next_s.write_en     = 1'b0;
                end else begin
                    cw_next_s.read_en = 1'b0;
                end
            end
            MEM:     cw_next_s = dec_cw_s;
            default: cw_next_s = CW_ZERO;
        endcase
    end

    // Output registers; reset clears everything so no pending write can complete.
    always_ff @(posedge clock) begin
        if (reset) begin
            cw_r      <= CW_ZERO;
            ready_r   <= 1'b0;
            done_r    <= 1'b0;
            illegal_r <= 1'b0;
        end else begin
            cw_r      <= cw_next_s;
            ready_r   <= (state_next_s == IDLE);
            done_r    <= (state_next_s == DONE);
            illegal_r <= illegal_next_s;
        end
    end

    assign instr_ready  = ready_r;
    assign done         = done_r;
    assign illegal      = illegal_r;
    assign SA           = cw_r.sa;
    assign SB           = cw_r.sb;
    assign DA           = cw_r.da;
    assign W            = cw_r.w;
    assign FS           = cw_r.fs;
    assign Cin          = cw_r.cin;
    assign selbork      = cw_r.selbork;
    assign k            = cw_r.k;
    assign triSelBtoD   = cw_r.tri_b_to_d;
    assign triSelFtoD   = cw_r.tri_f_to_d;
    assign triSelFtoA   = cw_r.tri_f_to_a;
    assign triSelOuttoD = cw_r.tri_out_to_d;
    assign writeEn      = cw_r.write_en;
    assign readEn       = cw_r.read_en;

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed testbench for legv8_control_unit with hand-computed control words.
module tb_legv8_control_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr = 32'd0;
    logic        instr_valid = 1'b0;
    logic        instr_ready, done, illegal, W, Cin, selbork;
    logic        triSelBtoD, triSelFtoD, triSelFtoA, triSelOuttoD, writeEn, readEn;
    logic [4:0]  SA, SB, DA, FS;
    logic [63:0] k;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_s;

    // obs = {SA, SB, DA, FS, W, Cin, selbork, BtoD, FtoD, FtoA, OuttoD, writeEn, readEn, done, illegal, instr_ready}
    logic [31:0] obs;
    assign obs = {SA, SB, DA, FS, W, Cin, selbork, triSelBtoD, triSelFtoD, triSelFtoA,
                  triSelOuttoD, writeEn, readEn, done, illegal, instr_ready};

    legv8_control_unit dut (
        .clock(clock), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .done(done), .illegal(illegal),
        .SA(SA), .SB(SB), .DA(DA), .W(W), .FS(FS), .Cin(Cin), .selbork(selbork), .k(k),
        .triSelBtoD(triSelBtoD), .triSelFtoD(triSelFtoD), .triSelFtoA(triSelFtoA),
        .triSelOuttoD(triSelOuttoD), .writeEn(writeEn), .readEn(readEn)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        tick(); tick();
        n_checks++;
        if (obs !== 32'h0) begin n_fail++; $display("FAIL reset_outputs: got %h expected %h", obs, 32'h0); end
        n_checks++;
        if (k !== 64'd0) begin n_fail++; $display("FAIL reset_k: got %h expected %h", k, 64'd0); end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs !== 32'h1) begin n_fail++; $display("FAIL reset_release_ready: got %h expected %h", obs, 32'h1); end
    endtask

    task automatic test_add();
        instr = 32'h8B020023; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if (obs !== 32'h0) begin n_fail++; $display("FAIL add_decode: got %h expected %h", obs, 32'h0); end
        tick();
        exp_s = {5'd1, 5'd2, 5'd3, 5'h08, 12'b1000_1000_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL add_exec: got %h expected %h", obs, exp_s); end
        tick();
        exp_s = {20'h0, 12'b0000_0000_0100};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL add_done: got %h expected %h", obs, exp_s); end
        tick();
        n_checks++;
        if (obs !== 32'h1) begin n_fail++; $display("FAIL add_ready: got %h expected %h", obs, 32'h1); end
    endtask

    task automatic test_sub();
        instr = 32'hCB090107; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        exp_s = {5'd8, 5'd9, 5'd7, 5'h09, 12'b1100_1000_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL sub_exec: got %h expected %h", obs, exp_s); end
        tick(); tick();
    endtask

    task automatic test_addi();
        instr = 32'h91002805; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        exp_s = {5'd0, 5'd0, 5'd5, 5'h08, 12'b1010_1000_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL addi_exec: got %h expected %h", obs, exp_s); end
        n_checks++;
        if (k !== 64'd10) begin n_fail++; $display("FAIL addi_k: got %h expected %h", k, 64'd10); end
        tick(); tick();
    endtask

    task automatic test_ldur();
        instr = 32'hF85F8024; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        exp_s = {5'd1, 5'd0, 5'd0, 5'h08, 12'b0010_0100_1000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL ldur_exec: got %h expected %h", obs, exp_s); end
        n_checks++;
        if (k !== 64'hFFFF_FFFF_FFFF_FFF8) begin n_fail++; $display("FAIL ldur_k: got %h expected %h", k, 64'hFFFF_FFFF_FFFF_FFF8); end
        tick();
        exp_s = {5'd1, 5'd0, 5'd4, 5'h08, 12'b1010_0110_1000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL ldur_mem: got %h expected %h", obs, exp_s); end
        tick();
        exp_s = {20'h0, 12'b0000_0000_0100};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL ldur_done: got %h expected %h", obs, exp_s); end
        tick();
        n_checks++;
        if (obs !== 32'h1) begin n_fail++; $display("FAIL ldur_ready: got %h expected %h", obs, 32'h1); end
    endtask

    task automatic test_stur();
        instr = 32'hF8000022; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        exp_s = {5'd1, 5'd0, 5'd0, 5'h08, 12'b0010_0100_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL stur_exec: got %h expected %h", obs, exp_s); end
        tick();
        exp_s = {5'd1, 5'd2, 5'd0, 5'h08, 12'b0011_0101_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL stur_mem: got %h expected %h", obs, exp_s); end
        tick();
        exp_s = {20'h0, 12'b0000_0000_0100};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL stur_done: got %h expected %h", obs, exp_s); end
        tick();
    endtask

    task automatic test_illegal();
        instr = 32'h00000000; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        exp_s = {20'h0, 12'b0000_0000_0011};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL illegal_pulse: got %h expected %h", obs, exp_s); end
        n_checks++;
        if (k !== 64'd0) begin n_fail++; $display("FAIL illegal_k: got %h expected %h", k, 64'd0); end
        tick();
        n_checks++;
        if (obs !== 32'h1) begin n_fail++; $display("FAIL illegal_one_cycle: got %h expected %h", obs, 32'h1); end
    endtask

    task automatic test_rd31();
        instr = 32'h8B02003F; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick();
        exp_s = {5'd1, 5'd2, 5'd31, 5'h08, 12'b0000_1000_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL rd31_exec: got %h expected %h", obs, exp_s); end
        tick();
        exp_s = {20'h0, 12'b0000_0000_0100};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL rd31_done: got %h expected %h", obs, exp_s); end
        tick();
    endtask

    task automatic test_back_to_back();
        instr = 32'h8B020023; instr_valid = 1'b1;
        tick(); tick();
        exp_s = {5'd1, 5'd2, 5'd3, 5'h08, 12'b1000_1000_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL b2b_first_exec: got %h expected %h", obs, exp_s); end
        tick(); tick();
        n_checks++;
        if (obs !== 32'h1) begin n_fail++; $display("FAIL b2b_ready_gap: got %h expected %h", obs, 32'h1); end
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if (obs !== 32'h0) begin n_fail++; $display("FAIL b2b_second_accept: got %h expected %h", obs, 32'h0); end
        tick();
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL b2b_second_exec: got %h expected %h", obs, exp_s); end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        instr = 32'hF8000022; instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (writeEn !== 1'b1) begin n_fail++; $display("FAIL rstmid_mem_write: got %b expected %b", writeEn, 1'b1); end
        reset = 1'b1;
        instr = 32'h8B020023; instr_valid = 1'b1;
        tick();
        n_checks++;
        if (obs !== 32'h0) begin n_fail++; $display("FAIL rstmid_cleared: got %h expected %h", obs, 32'h0); end
        n_checks++;
        if (k !== 64'd0) begin n_fail++; $display("FAIL rstmid_k: got %h expected %h", k, 64'd0); end
        tick();
        n_checks++;
        if (obs !== 32'h0) begin n_fail++; $display("FAIL rstmid_held_valid: got %h expected %h", obs, 32'h0); end
        reset = 1'b0;
        tick();
        n_checks++;
        if (obs !== 32'h1) begin n_fail++; $display("FAIL rstmid_ready_after: got %h expected %h", obs, 32'h1); end
        tick();
        instr_valid = 1'b0;
        n_checks++;
        if (obs !== 32'h0) begin n_fail++; $display("FAIL rstmid_accept: got %h expected %h", obs, 32'h0); end
        tick();
        exp_s = {5'd1, 5'd2, 5'd3, 5'h08, 12'b1000_1000_0000};
        n_checks++;
        if (obs !== exp_s) begin n_fail++; $display("FAIL rstmid_exec: got %h expected %h", obs, exp_s); end
        tick(); tick();
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_addi();
        test_ldur();
        test_stur();
        test_illegal();
        test_rd31();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
